// File: rtl/game_pkg.sv
// Shared game-logic types and constants: scheduler state encoding and per-kind spawn cadence.
package game_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, PENDING, OFFER} sched_state_t;

  localparam int GAME_TIME_W = 11;
  localparam int PERIOD_W    = 8;

  localparam logic [2:0] KIND_FALLING = 3'd7;

  // Frames between spawns, indexed by kind (levels 0..6, then falling square); every entry >= 2.
  localparam logic [PERIOD_W-1:0] SPAWN_PERIOD [0:7] = '{
    8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd5, 8'd3
  };

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin free-slot finder: first set bit of free at or after ptr, wrapping around.
module rr_free_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         free,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int s;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    s     = 0;
    for (int k = 0; k < N; k++) begin
      s = (int'(ptr) + k) % N;
      if (!found && free[s[IW-1:0]]) begin
        found = 1'b1;
        idx   = IW'(s);
      end
    end
  end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Game clock and obstacle spawn sequencer: counts frames, paces spawns per level kind and
// hands each spawn, with a round-robin free slot and an LFSR lane, to the renderer.
module obstacle_spawn_scheduler
  import game_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          NUM_LANES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [6:0]                   level_sel,
  input  logic                         falling_en,
  input  logic                         clear_objs,
  input  logic                         player_died,
  input  logic [NUM_SLOTS-1:0]         slot_done,
  input  logic                         spawn_ready,
  output logic [GAME_TIME_W-1:0]       game_time,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic [$clog2(NUM_LANES)-1:0] spawn_lane,
  output logic [2:0]                   spawn_kind,
  output logic [NUM_SLOTS-1:0]         slot_active
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int LANE_W = $clog2(NUM_LANES);

  sched_state_t          state, state_d;
  logic [PERIOD_W-1:0]   frame_cnt;
  logic [15:0]           lfsr;
  logic [SLOT_W-1:0]     rr_ptr;
  logic [SLOT_W-1:0]     pick_idx;
  logic                  pick_found;
  logic [NUM_SLOTS-1:0]  free_mask;
  logic [NUM_SLOTS-1:0]  accept_mask;
  logic [2:0]            kind_now;
  logic                  run, flush, accept, period_end;

  assign run         = (|level_sel) | falling_en;
  assign flush       = player_died | clear_objs;
  assign spawn_valid = (state == OFFER);
  assign accept      = spawn_valid & spawn_ready;
  // A slot finishing this cycle is already usable for a waiting spawn.
  assign free_mask   = ~(slot_active & ~slot_done);
  // >= so a level change to a shorter period cannot strand the counter above its limit.
  assign period_end  = frame_tick && (frame_cnt >= (SPAWN_PERIOD[kind_now] - 8'd1));

  always_comb begin
    kind_now = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (level_sel[i]) kind_now = 3'(i);
    end
    if (falling_en) kind_now = KIND_FALLING;
  end

  always_comb begin
    accept_mask = '0;
    if (accept) accept_mask[spawn_slot] = 1'b1;
  end

  rr_free_picker #(.N(NUM_SLOTS)) u_picker (
    .free  (free_mask),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (run) state_d = COUNT;
      COUNT:   if (period_end) state_d = PENDING;
      PENDING: if (pick_found) state_d = OFFER;
      OFFER:   if (spawn_ready) state_d = COUNT;
      default: state_d = IDLE;
    endcase
    if (!run) state_d = IDLE;
    if (flush) state_d = run ? COUNT : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      game_time <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      if (flush || !run)                     frame_cnt <= '0;
      else if (state == COUNT && frame_tick) frame_cnt <= period_end ? '0 : frame_cnt + 8'd1;

      if (player_died || !run)               game_time <= '0;
      else if (frame_tick && game_time != '1) game_time <= game_time + 11'd1;

      if (frame_tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Offer fields are captured once and held until the handshake completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spawn_slot <= '0;
      spawn_lane <= '0;
      spawn_kind <= '0;
    end else if (state == PENDING && state_d == OFFER) begin
      spawn_slot <= pick_idx;
      spawn_lane <= lfsr[LANE_W-1:0];
      spawn_kind <= kind_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_active <= '0;
      rr_ptr      <= '0;
    end else begin
      if (accept) rr_ptr <= (spawn_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : spawn_slot + 1'b1;
      if (flush) slot_active <= '0;
      else       slot_active <= (slot_active & ~slot_done) | accept_mask;
    end
  end

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Bench for obstacle_spawn_scheduler: directed scenarios plus random traffic, scored against a
// behavioural model whose predicted offers are queued and matched by a negedge monitor.
module tb_obstacle_spawn_scheduler;
  import game_pkg::*;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [6:0]  level_sel;
  logic        falling_en;
  logic        clear_objs;
  logic        player_died;
  logic [3:0]  slot_done;
  logic        spawn_ready;
  logic [10:0] game_time;
  logic        spawn_valid;
  logic [1:0]  spawn_slot;
  logic [2:0]  spawn_lane;
  logic [2:0]  spawn_kind;
  logic [3:0]  slot_active;

  obstacle_spawn_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .level_sel   (level_sel),
    .falling_en  (falling_en),
    .clear_objs  (clear_objs),
    .player_died (player_died),
    .slot_done   (slot_done),
    .spawn_ready (spawn_ready),
    .game_time   (game_time),
    .spawn_valid (spawn_valid),
    .spawn_slot  (spawn_slot),
    .spawn_lane  (spawn_lane),
    .spawn_kind  (spawn_kind),
    .slot_active (slot_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int slot;
    int lane;
    int kind;
  } offer_t;

  offer_t exp_q[$];
  offer_t acc_q[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the scheduler's observable behaviour.
  int          m_gt;
  logic [3:0]  m_occ;
  int          m_rr;
  logic [15:0] m_lfsr;
  bit          m_armed, m_owed, m_offering;
  int          m_frames;
  int          m_off_slot;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_reset();
    m_gt = 0; m_occ = '0; m_rr = 0; m_lfsr = 16'hACE1;
    m_armed = 0; m_owed = 0; m_offering = 0; m_frames = 0; m_off_slot = 0;
  endtask

  task automatic model_step();
    bit run, flush, accept;
    int kind, period, pick, s;
    logic [3:0] free;
    logic [15:0] lane_src;
    offer_t o;
    run    = (level_sel != 0) || falling_en;
    kind   = 0;
    for (int i = 6; i >= 0; i--) if (level_sel[i]) kind = i;
    if (falling_en) kind = 7;
    period = int'(SPAWN_PERIOD[kind]);
    flush  = player_died || clear_objs;
    accept = m_offering && spawn_ready;
    free   = ~(m_occ & ~slot_done);
    lane_src = m_lfsr;
    if (frame_tick) m_lfsr = lfsr_next(m_lfsr);
    if (player_died || !run) m_gt = 0;
    else if (frame_tick && m_gt < 2047) m_gt++;
    m_occ = m_occ & ~slot_done;
    if (accept) begin
      m_occ[m_off_slot] = 1'b1;
      m_rr = (m_off_slot + 1) % NS;
    end
    if (flush) m_occ = '0;
    if (m_offering && !accept && (flush || !run) && exp_q.size() > 0) void'(exp_q.pop_front());
    if (flush) begin
      m_armed = run; m_owed = 0; m_offering = 0; m_frames = 0;
    end else if (!run) begin
      m_armed = 0; m_owed = 0; m_offering = 0; m_frames = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (m_offering) begin
      if (accept) m_offering = 0;
    end else if (m_owed) begin
      pick = -1;
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (pick < 0 && free[s]) pick = s;
      end
      if (pick >= 0) begin
        m_off_slot = pick;
        o.slot = pick; o.lane = int'(lane_src[2:0]); o.kind = kind;
        exp_q.push_back(o);
        m_offering = 1; m_owed = 0;
      end
    end else if (frame_tick) begin
      m_frames++;
      if (m_frames >= period) begin
        m_frames = 0; m_owed = 1;
      end
    end
  endtask

  // Monitor: compare at negedge, then advance the model with the inputs the next edge will see.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        model_reset();
        exp_q.delete();
      end else begin
        chk("valid", int'(spawn_valid), int'(m_offering));
        chk("game_time", int'(game_time), m_gt);
        chk("slot_active", int'(slot_active), int'(m_occ));
        if (spawn_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL offer_unexpected: got valid=1 slot=%0d, expected no offer (t=%0t)", spawn_slot, $time);
          end else begin
            chk("offer_slot", int'(spawn_slot), exp_q[0].slot);
            chk("offer_lane", int'(spawn_lane), exp_q[0].lane);
            chk("offer_kind", int'(spawn_kind), exp_q[0].kind);
            if (spawn_ready) begin
              offer_t a;
              a.slot = int'(spawn_slot); a.lane = int'(spawn_lane); a.kind = int'(spawn_kind);
              acc_q.push_back(a);
              void'(exp_q.pop_front());
            end
          end
        end
        model_step();
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      repeat (gap - 1) cyc();
    end
  endtask

  task automatic wait_offer(input string name);
    for (int i = 0; i < 30 && !spawn_valid; i++) cyc();
    chk(name, int'(spawn_valid), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 0; level_sel = '0; falling_en = 0; clear_objs = 0;
    player_died = 0; slot_done = '0; spawn_ready = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_game_time", int'(game_time), 0);
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_slot_active", int'(slot_active), 0);
    chk("rst_offer_fields", int'({spawn_slot, spawn_lane, spawn_kind}), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    acc_q.delete();
  endtask

  initial begin
    int k7;
    reset = 1'b1;
    frame_tick = 0; level_sel = '0; falling_en = 0; clear_objs = 0;
    player_died = 0; slot_done = '0; spawn_ready = 0;

    // Two spawns from nine frames of level 0.
    do_reset();
    level_sel = 7'b0000001; spawn_ready = 1;
    cyc();
    ticks(9, 4);
    repeat (4) cyc();
    @(negedge clk);
    chk("t1_spawn_count", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      chk("t1_first_slot", acc_q[0].slot, 0);
      chk("t1_second_slot", acc_q[1].slot, 1);
      chk("t1_kind", acc_q[1].kind, 0);
    end
    chk("t1_game_time", int'(game_time), 9);

    // All slots busy, then slot 2 frees up.
    do_reset();
    level_sel = 7'b0000001; spawn_ready = 1;
    cyc();
    frame_tick = 1;
    repeat (40) cyc();
    frame_tick = 0;
    repeat (2) cyc();
    @(negedge clk);
    chk("t2_blocked_valid", int'(spawn_valid), 0);
    chk("t2_full", int'(slot_active), 15);
    @(posedge clk);
    #1 slot_done = 4'b0100;
    cyc();
    slot_done = '0;
    @(negedge clk);
    chk("t2_valid_after_done", int'(spawn_valid), 1);
    chk("t2_slot", int'(spawn_slot), 2);

    // Offer held under back-pressure across a level change.
    do_reset();
    level_sel = 7'b0000001; spawn_ready = 0;
    cyc();
    ticks(4, 4);
    wait_offer("t3_offer_seen");
    for (int i = 0; i < 20; i++) begin
      if (i == 10) level_sel = 7'b0001000;
      cyc();
    end
    @(negedge clk);
    chk("t3_kind_held", int'(spawn_kind), 0);
    @(posedge clk);
    #1 spawn_ready = 1;
    cyc();
    spawn_ready = 0;
    @(negedge clk);
    chk("t3_valid_dropped", int'(spawn_valid), 0);
    chk("t3_slot_set", int'(slot_active), 1);

    // Death during an offer with three slots active.
    do_reset();
    level_sel = 7'b0000001; spawn_ready = 1;
    cyc();
    ticks(12, 4);
    repeat (4) cyc();
    spawn_ready = 0;
    ticks(4, 4);
    wait_offer("t4_offer_seen");
    chk("t4_three_active", int'(slot_active), 7);
    player_died = 1;
    cyc();
    player_died = 0;
    @(negedge clk);
    chk("t4_valid", int'(spawn_valid), 0);
    chk("t4_slot_active", int'(slot_active), 0);
    chk("t4_game_time", int'(game_time), 0);

    // Clear coinciding with slot_done and acceptance.
    do_reset();
    level_sel = 7'b0000001; spawn_ready = 1;
    cyc();
    ticks(8, 4);
    repeat (4) cyc();
    spawn_ready = 0;
    ticks(4, 4);
    wait_offer("t5_offer_seen");
    clear_objs = 1; slot_done = 4'b0010; spawn_ready = 1;
    cyc();
    clear_objs = 0; slot_done = '0; spawn_ready = 0;
    @(negedge clk);
    chk("t5_slot_active", int'(slot_active), 0);
    chk("t5_game_time", int'(game_time), 12);

    // Falling-square phase running past game_time saturation.
    do_reset();
    falling_en = 1; spawn_ready = 1;
    cyc();
    frame_tick = 1;
    repeat (2100) begin
      slot_done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cyc();
    end
    frame_tick = 0; slot_done = '0;
    @(negedge clk);
    chk("t6_game_time_sat", int'(game_time), 2047);
    k7 = 0;
    foreach (acc_q[i]) if (acc_q[i].kind == 7) k7++;
    chk("t6_kind7_spawned", int'(k7 > 50), 1);
    chk("t6_all_kind7", k7, acc_q.size());

    // Random traffic.
    do_reset();
    level_sel = 7'b0000100;
    repeat (3000) begin
      frame_tick  = ($urandom_range(0, 2) == 0);
      spawn_ready = 1'($urandom_range(0, 1));
      slot_done   = '0;
      for (int b = 0; b < 4; b++) slot_done[b] = ($urandom_range(0, 7) == 0);
      player_died = ($urandom_range(0, 199) == 0);
      clear_objs  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 3) == 0) level_sel = 7'($urandom_range(0, 127));
        else                           level_sel = 7'b1 << $urandom_range(0, 6);
      end
      if ($urandom_range(0, 199) == 0) falling_en = ~falling_en;
      cyc();
    end
    frame_tick = 0; spawn_ready = 0; slot_done = '0; player_died = 0; clear_objs = 0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
